// File: rtl/alu_pkg.sv
`default_nettype none
// ============================================================================
// Module      : alu_pkg
// Description : Shared constants for the MIPS execute stage: ALU operation
//               codes, execute FSM state encoding and default datapath width.
// Revision    : 1.0 - initial release
// ============================================================================
package alu_pkg;

    // Default operand / result width
    localparam int unsigned c_width_default = 16;

    // Operation codes driven by ALU control
    localparam logic [3:0] c_op_add  = 4'b0000;
    localparam logic [3:0] c_op_sub  = 4'b0001;
    localparam logic [3:0] c_op_mul  = 4'b0010;
    localparam logic [3:0] c_op_div  = 4'b0011;
    localparam logic [3:0] c_op_and  = 4'b0100;
    localparam logic [3:0] c_op_swap = 4'b0101;
    localparam logic [3:0] c_op_or   = 4'b0111;
    localparam logic [3:0] c_op_addr = 4'b1000;

    // Execute FSM state encoding
    localparam logic [1:0] c_st_idle = 2'd0;
    localparam logic [1:0] c_st_mul  = 2'd1;
    localparam logic [1:0] c_st_div  = 2'd2;

endpackage : alu_pkg
`default_nettype wire

// File: rtl/alu_muldiv_iter.sv
`default_nettype none
// ============================================================================
// Module      : alu_muldiv_iter
// Description : Iterative unsigned multiply (shift-add) and restoring divide,
//               one bit per cycle. A single 2*WIDTH accumulator holds either
//               {partial product, multiplier} or {remainder, dividend/quotient}.
//               done/lo/hi are the combinational results of the final step,
//               so the parent registers them on the same edge.
// Revision    : 1.0 - initial release
// ============================================================================
module alu_muldiv_iter
    import alu_pkg::*;
#(
    parameter int unsigned WIDTH = c_width_default
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             abort,
    input  logic             start,
    input  logic             mode,   // 0 = multiply, 1 = divide
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             done,
    output logic [WIDTH-1:0] lo,
    output logic [WIDTH-1:0] hi
);

    localparam int unsigned    c_cw   = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [c_cw-1:0] c_last = c_cw'(WIDTH - 1);

    logic                 r_busy;
    logic                 r_mode;
    logic [c_cw-1:0]      r_cnt;
    logic [2*WIDTH-1:0]   r_acc;
    logic [WIDTH-1:0]     r_opnd;   // multiplicand or divisor

    logic [WIDTH:0]       w_mul_sum;
    logic [2*WIDTH-1:0]   w_mul_next;
    logic [WIDTH:0]       w_div_shift;
    logic [WIDTH:0]       w_div_diff;
    logic                 w_div_ge;
    logic [2*WIDTH-1:0]   w_div_next;
    logic [2*WIDTH-1:0]   w_acc_next;

    // Multiply: add multiplicand to upper half when multiplier LSB is set, then shift right
    assign w_mul_sum  = {1'b0, r_acc[2*WIDTH-1:WIDTH]} + (r_acc[0] ? {1'b0, r_opnd} : '0);
    assign w_mul_next = {w_mul_sum, r_acc[WIDTH-1:1]};

    // Divide: shift next dividend bit into remainder, subtract divisor if it fits
    assign w_div_shift = {r_acc[2*WIDTH-1:WIDTH], r_acc[WIDTH-1]};
    assign w_div_diff  = w_div_shift - {1'b0, r_opnd};
    assign w_div_ge    = (w_div_shift >= {1'b0, r_opnd});
    assign w_div_next  = {(w_div_ge ? w_div_diff[WIDTH-1:0] : w_div_shift[WIDTH-1:0]),
                          r_acc[WIDTH-2:0], w_div_ge};

    assign w_acc_next = r_mode ? w_div_next : w_mul_next;

    assign done = r_busy && (r_cnt == c_last);
    assign lo   = w_acc_next[WIDTH-1:0];
    assign hi   = w_acc_next[2*WIDTH-1:WIDTH];

    // Load operands on start, then advance one iteration per cycle until the last
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_busy <= 1'b0;
            r_mode <= 1'b0;
            r_cnt  <= '0;
            r_acc  <= '0;
            r_opnd <= '0;
        end else if (abort) begin
            r_busy <= 1'b0;
            r_cnt  <= '0;
        end else if (start) begin
            r_busy <= 1'b1;
            r_mode <= mode;
            r_cnt  <= '0;
            r_acc  <= mode ? {{WIDTH{1'b0}}, a} : {{WIDTH{1'b0}}, b};
            r_opnd <= mode ? b : a;
        end else if (r_busy) begin
            r_acc <= w_acc_next;
            if (r_cnt == c_last) begin
                r_busy <= 1'b0;
                r_cnt  <= '0;
            end else begin
                r_cnt <= r_cnt + 1'b1;
            end
        end
    end

endmodule : alu_muldiv_iter
`default_nettype wire

// File: rtl/alu_exec.sv
`default_nettype none
// ============================================================================
// Module      : alu_exec
// Description : MIPS execute-stage ALU. Single-cycle operations register in
//               one clock; multiply/divide run in alu_muldiv_iter while issue
//               is stalled through in_ready. flush kills any in-flight work.
// Revision    : 1.0 - initial release
// ============================================================================
module alu_exec
    import alu_pkg::*;
#(
    parameter int unsigned WIDTH = c_width_default
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       operation,
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
    output logic             out_valid,
    output logic [WIDTH-1:0] result,
    output logic [WIDTH-1:0] result_hi,
    output logic             zero,
    output logic             overflow
);

    logic [1:0]       r_state;
    logic             r_out_valid;
    logic [WIDTH-1:0] r_result;
    logic [WIDTH-1:0] r_result_hi;
    logic             r_zero;
    logic             r_overflow;

    logic [WIDTH-1:0] w_sum;
    logic [WIDTH-1:0] w_diff;
    logic [WIDTH-1:0] w_res;
    logic [WIDTH-1:0] w_hi;
    logic             w_ovf;
    logic             w_known;
    logic             w_accept;
    logic             w_is_mul;
    logic             w_is_div;
    logic             w_start;
    logic             w_it_done;
    logic [WIDTH-1:0] w_it_lo;
    logic [WIDTH-1:0] w_it_hi;

    assign w_sum    = op_a + op_b;
    assign w_diff   = op_a - op_b;
    assign w_accept = !flush && (r_state == c_st_idle) && in_valid;
    assign w_is_mul = (operation == c_op_mul);
    assign w_is_div = (operation == c_op_div);
    assign w_start  = w_accept && (w_is_mul || (w_is_div && (op_b != '0)));

    assign in_ready  = (r_state == c_st_idle);
    assign out_valid = r_out_valid;
    assign result    = r_result;
    assign result_hi = r_result_hi;
    assign zero      = r_zero;
    assign overflow  = r_overflow;

    // Single-cycle result, secondary result and overflow; unknown codes yield all zeros
    always_comb begin
        w_res   = '0;
        w_hi    = '0;
        w_ovf   = 1'b0;
        w_known = 1'b1;
        case (operation)
            c_op_add: begin
                w_res = w_sum;
                w_ovf = (op_a[WIDTH-1] == op_b[WIDTH-1]) && (w_sum[WIDTH-1] != op_a[WIDTH-1]);
            end
            c_op_sub: begin
                w_res = w_diff;
                w_ovf = (op_a[WIDTH-1] != op_b[WIDTH-1]) && (w_diff[WIDTH-1] != op_a[WIDTH-1]);
            end
            c_op_and:  w_res = op_a & op_b;
            c_op_swap: begin
                w_res = op_b;
                w_hi  = op_a;
            end
            c_op_or:   w_res = op_a | op_b;
            c_op_addr: w_res = w_sum;
            default:   w_known = 1'b0;
        endcase
    end

    alu_muldiv_iter #(
        .WIDTH (WIDTH)
    ) u_muldiv (
        .clk   (clk),
        .rst_n (rst_n),
        .abort (flush),
        .start (w_start),
        .mode  (w_is_div),
        .a     (op_a),
        .b     (op_b),
        .done  (w_it_done),
        .lo    (w_it_lo),
        .hi    (w_it_hi)
    );

    // Execute FSM: issue, iterate, complete; output data holds between pulses
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= c_st_idle;
            r_out_valid <= 1'b0;
            r_result    <= '0;
            r_result_hi <= '0;
            r_zero      <= 1'b0;
            r_overflow  <= 1'b0;
        end else begin
            r_out_valid <= 1'b0;
            if (flush) begin
                r_state <= c_st_idle;
            end else begin
                case (r_state)
                    c_st_idle: begin
                        if (in_valid) begin
                            if (w_is_mul) begin
                                r_state <= c_st_mul;
                            end else if (w_is_div && (op_b != '0)) begin
                                r_state <= c_st_div;
                            end else if (w_is_div) begin
                                // Divide by zero completes immediately
                                r_result    <= '1;
                                r_result_hi <= op_a;
                                r_zero      <= 1'b0;
                                r_overflow  <= 1'b0;
                                r_out_valid <= 1'b1;
                            end else begin
                                r_result    <= w_res;
                                r_result_hi <= w_hi;
                                r_zero      <= w_known && (w_res == '0);
                                r_overflow  <= w_ovf;
                                r_out_valid <= 1'b1;
                            end
                        end
                    end
                    c_st_mul, c_st_div: begin
                        if (w_it_done) begin
                            r_result    <= w_it_lo;
                            r_result_hi <= w_it_hi;
                            r_zero      <= (w_it_lo == '0);
                            r_overflow  <= 1'b0;
                            r_out_valid <= 1'b1;
                            r_state     <= c_st_idle;
                        end
                    end
                    default: r_state <= c_st_idle;
                endcase
            end
        end
    end

endmodule : alu_exec
`default_nettype wire

// File: tb/tb_alu_exec.sv
`default_nettype none
// ============================================================================
// Module      : tb_alu_exec
// Description : Self-checking bench for alu_exec: directed corner cases plus a
//               randomized operation stream against an arithmetic reference.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_alu_exec;

    localparam int unsigned W = 16;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         flush;
    logic         in_valid;
    logic         in_ready;
    logic [3:0]   operation;
    logic [W-1:0] op_a;
    logic [W-1:0] op_b;
    logic         out_valid;
    logic [W-1:0] result;
    logic [W-1:0] result_hi;
    logic         zero;
    logic         overflow;

    int n_cmp = 0;
    int n_err = 0;

    alu_exec #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .operation (operation),
        .op_a      (op_a),
        .op_b      (op_b),
        .out_valid (out_valid),
        .result    (result),
        .result_hi (result_hi),
        .zero      (zero),
        .overflow  (overflow)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: observed 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Reference: plain arithmetic on the operation table
    task automatic model(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                         output logic [W-1:0] r, output logic [W-1:0] h,
                         output logic z, output logic o, output int lat);
        int           s;
        logic [31:0]  p;
        logic         known;
        r = '0; h = '0; o = 1'b0; lat = 1; known = 1'b1;
        case (op)
            4'd0: begin
                s = int'($signed(a)) + int'($signed(b));
                r = a + b;
                o = (s > 32767) || (s < -32768);
            end
            4'd1: begin
                s = int'($signed(a)) - int'($signed(b));
                r = a - b;
                o = (s > 32767) || (s < -32768);
            end
            4'd2: begin
                p = 32'(a) * 32'(b);
                r = p[15:0];
                h = p[31:16];
                lat = W + 1;
            end
            4'd3: begin
                if (b == 0) begin
                    r = 16'hFFFF;
                    h = a;
                end else begin
                    r = a / b;
                    h = a % b;
                    lat = W + 1;
                end
            end
            4'd4: r = a & b;
            4'd5: begin r = b; h = a; end
            4'd7: r = a | b;
            4'd8: r = a + b;
            default: known = 1'b0;
        endcase
        z = known && (r == 0);
    endtask

    // Issue one operation and check latency, stall window and outputs
    task automatic do_op(input string tag, input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
        logic [W-1:0] er, eh;
        logic         ez, eo;
        int           lat, cyc, lowc;
        model(op, a, b, er, eh, ez, eo, lat);
        operation = op; op_a = a; op_b = b; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        cyc = 1; lowc = 0;
        while (!out_valid && cyc <= W + 4) begin
            if (!in_ready) lowc++;
            @(posedge clk); #1;
            cyc++;
        end
        check({tag, ".latency"}, cyc, lat);
        check({tag, ".stall"}, lowc, lat - 1);
        check({tag, ".ready"}, in_ready, 1);
        check({tag, ".result"}, result, er);
        check({tag, ".result_hi"}, result_hi, eh);
        check({tag, ".zero"}, zero, ez);
        check({tag, ".overflow"}, overflow, eo);
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, ".in_ready"}, in_ready, 1);
        check({tag, ".out_valid"}, out_valid, 0);
        check({tag, ".result"}, result, 0);
        check({tag, ".result_hi"}, result_hi, 0);
        check({tag, ".zero"}, zero, 0);
        check({tag, ".overflow"}, overflow, 0);
    endtask

    initial begin
        int pulses;
        logic [3:0]   op;
        logic [W-1:0] a, b;

        rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0;
        operation = '0; op_a = '0; op_b = '0;
        repeat (3) @(posedge clk);
        #1;
        check_reset_vals("reset");
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk); #1;

        do_op("add_ovf", 4'b0000, 16'h7FFF, 16'h0001);
        do_op("sub_zero", 4'b0001, 16'h0005, 16'h0005);
        do_op("mul", 4'b0010, 16'h1234, 16'h0100);
        do_op("div", 4'b0011, 16'd100, 16'd7);
        do_op("div0", 4'b0011, 16'h00AB, 16'h0000);
        do_op("swap", 4'b0101, 16'hAAAA, 16'h5555);

        // Outputs hold between pulses
        @(posedge clk); #1;
        check("hold.out_valid", out_valid, 0);
        check("hold.result", result, 16'h5555);
        check("hold.result_hi", result_hi, 16'hAAAA);

        do_op("bad_code", 4'b1010, 16'h1234, 16'h4321);
        do_op("addr", 4'b1000, 16'h7FFF, 16'h0001);
        do_op("and", 4'b0100, 16'hFFFF, 16'h0F0F);

        // Flush in cycle 8 of a divide
        operation = 4'b0011; op_a = 16'd1000; op_b = 16'd3; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (7) begin @(posedge clk); #1; end
        flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0;
        check("flush.out_valid", out_valid, 0);
        check("flush.in_ready", in_ready, 1);
        check("flush.result_held", result, 16'h0F0F);
        do_op("or_after_flush", 4'b0111, 16'h00F0, 16'h0F00);
        pulses = 0;
        repeat (W + 2) begin
            @(posedge clk); #1;
            if (out_valid) pulses++;
        end
        check("flush.no_late_pulse", pulses, 0);

        // Reset asserted mid-multiply
        operation = 4'b0010; op_a = 16'h0003; op_b = 16'h0005; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (5) begin @(posedge clk); #1; end
        check("mid_mul.in_ready", in_ready, 0);
        rst_n = 1'b0;
        #1;
        check_reset_vals("mid_mul_reset");
        @(negedge clk) rst_n = 1'b1;
        pulses = 0;
        repeat (W + 2) begin
            @(posedge clk); #1;
            if (out_valid) pulses++;
        end
        check("post_reset.no_pulse", pulses, 0);
        check("post_reset.in_ready", in_ready, 1);

        // Randomized operation stream
        for (int i = 0; i < 200; i++) begin
            op = 4'($urandom_range(0, 15));
            a  = W'($urandom);
            b  = ($urandom_range(0, 7) == 0) ? '0 : W'($urandom);
            if ($urandom_range(0, 3) == 0) b = W'($urandom_range(1, 20));
            do_op($sformatf("rand%0d_op%0h", i, op), op, a, b);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule : tb_alu_exec
`default_nettype wire
